// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and types for the 7-segment bus reader.
// Patterns are active-low {a,b,c,d,e,f,g}, bit 6 = a.
package seg7_pkg;

    typedef logic [6:0] seg7_pattern_t;

    localparam int SEG_A_BIT = 6;
    localparam int SEG_B_BIT = 5;
    localparam int SEG_C_BIT = 4;
    localparam int SEG_D_BIT = 3;
    localparam int SEG_E_BIT = 2;
    localparam int SEG_F_BIT = 1;
    localparam int SEG_G_BIT = 0;

    localparam seg7_pattern_t SEG_0     = 7'h01;
    localparam seg7_pattern_t SEG_1     = 7'h4F;
    localparam seg7_pattern_t SEG_2     = 7'h12;
    localparam seg7_pattern_t SEG_3     = 7'h06;
    localparam seg7_pattern_t SEG_4     = 7'h4C;
    localparam seg7_pattern_t SEG_5     = 7'h24;
    localparam seg7_pattern_t SEG_6     = 7'h20;
    localparam seg7_pattern_t SEG_7     = 7'h0F;
    localparam seg7_pattern_t SEG_8     = 7'h00;
    localparam seg7_pattern_t SEG_9     = 7'h04;
    localparam seg7_pattern_t SEG_A     = 7'h08;
    localparam seg7_pattern_t SEG_B     = 7'h60;
    localparam seg7_pattern_t SEG_C     = 7'h31;
    localparam seg7_pattern_t SEG_D     = 7'h42;
    localparam seg7_pattern_t SEG_E     = 7'h30;
    localparam seg7_pattern_t SEG_F     = 7'h38;
    localparam seg7_pattern_t SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg7_pattern_lookup.sv
// seg7_pattern_lookup: active-low segment pattern to hex value.
// hit = recognised glyph, blank = all segments off.
module seg7_pattern_lookup
    import seg7_pkg::*;
(
    input  seg7_pattern_t seg_n,
    output logic          hit,
    output logic          blank,
    output logic [3:0]    value
);

    // Reverse glyph table; anything unlisted is neither hit nor blank.
    always_comb begin
        hit   = 1'b1;
        blank = 1'b0;
        value = 4'h0;
        unique case (seg_n)
            SEG_0:     value = 4'h0;
            SEG_1:     value = 4'h1;
            SEG_2:     value = 4'h2;
            SEG_3:     value = 4'h3;
            SEG_4:     value = 4'h4;
            SEG_5:     value = 4'h5;
            SEG_6:     value = 4'h6;
            SEG_7:     value = 4'h7;
            SEG_8:     value = 4'h8;
            SEG_9:     value = 4'h9;
            SEG_A:     value = 4'hA;
            SEG_B:     value = 4'hB;
            SEG_C:     value = 4'hC;
            SEG_D:     value = 4'hD;
            SEG_E:     value = 4'hE;
            SEG_F:     value = 4'hF;
            SEG_BLANK: begin
                hit   = 1'b0;
                blank = 1'b1;
            end
            default:   hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_bus_reader.sv
// seg7_bus_reader: recovers hex digits from a multiplexed active-low
// 7-segment bus after a pattern has been stable for STABLE_CNT samples.
module seg7_bus_reader
    import seg7_pkg::*;
#(
    parameter  int NUM_DIGITS = 4,
    parameter  int STABLE_CNT = 3,
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
    localparam int CW = $clog2(STABLE_CNT + 1),
    localparam int SW = 7 + NUM_DIGITS
)
(
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [6:0]              seg_n,
    input  logic [NUM_DIGITS-1:0]   dig_en_n,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_ok,
    output logic                    upd_stb,
    output logic [IW-1:0]           upd_idx,
    output logic [3:0]              upd_val,
    output logic                    upd_blank,
    output logic                    upd_err
);

    logic [6:0]              seg_s1_q, seg_s1_d, seg_s2_q, seg_s2_d;
    logic [NUM_DIGITS-1:0]   en_s1_q, en_s1_d, en_s2_q, en_s2_d;
    logic [SW-1:0]           prev_q, prev_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   ok_q, ok_d;
    logic                    stb_q, stb_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [3:0]              val_q, val_d;
    logic                    blank_q, blank_d;
    logic                    err_q, err_d;

    logic [SW-1:0]         sample;
    logic [NUM_DIGITS-1:0] en_low;
    logic                  slot_ok;
    logic                  same;
    logic                  accept;
    logic                  lk_hit, lk_blank;
    logic [3:0]            lk_value;

    seg7_pattern_lookup u_lookup (
        .seg_n (seg_s2_q),
        .hit   (lk_hit),
        .blank (lk_blank),
        .value (lk_value)
    );

    // Sync, run counting, acceptance and register-bank update.
    always_comb begin
        seg_s1_d = seg_n;
        en_s1_d  = dig_en_n;
        seg_s2_d = seg_s1_q;
        en_s2_d  = en_s1_q;

        sample  = {seg_s2_q, en_s2_q};
        en_low  = ~en_s2_q;
        slot_ok = $onehot(en_low);
        same    = (sample == prev_q);
        prev_d  = sample;

        if (!slot_ok)
            cnt_d = '0;
        else if (!same)
            cnt_d = CW'(1);
        else if (cnt_q == CW'(STABLE_CNT))
            cnt_d = cnt_q;
        else
            cnt_d = cnt_q + CW'(1);

        // A changed sample only completes a run when one sample suffices.
        accept = slot_ok && (same ? (cnt_q == CW'(STABLE_CNT - 1))
                                  : (STABLE_CNT == 1));

        digits_d = digits_q;
        ok_d     = ok_q;
        stb_d    = 1'b0;
        idx_d    = '0;
        val_d    = 4'h0;
        blank_d  = 1'b0;
        err_d    = 1'b0;

        if (accept) begin
            stb_d   = 1'b1;
            blank_d = lk_blank;
            err_d   = !lk_hit && !lk_blank;
            val_d   = lk_hit ? lk_value : 4'h0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (en_low[i]) begin
                    idx_d   = i[IW-1:0];
                    ok_d[i] = lk_hit;
                    if (lk_hit)
                        digits_d[4*i +: 4] = lk_value;
                    else if (lk_blank)
                        digits_d[4*i +: 4] = 4'h0;
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg_s1_q <= '0;
            seg_s2_q <= '0;
            en_s1_q  <= '0;
            en_s2_q  <= '0;
            prev_q   <= '0;
            cnt_q    <= '0;
            digits_q <= '0;
            ok_q     <= '0;
            stb_q    <= 1'b0;
            idx_q    <= '0;
            val_q    <= 4'h0;
            blank_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            seg_s1_q <= seg_s1_d;
            seg_s2_q <= seg_s2_d;
            en_s1_q  <= en_s1_d;
            en_s2_q  <= en_s2_d;
            prev_q   <= prev_d;
            cnt_q    <= cnt_d;
            digits_q <= digits_d;
            ok_q     <= ok_d;
            stb_q    <= stb_d;
            idx_q    <= idx_d;
            val_q    <= val_d;
            blank_q  <= blank_d;
            err_q    <= err_d;
        end
    end

    assign digits    = digits_q;
    assign digit_ok  = ok_q;
    assign upd_stb   = stb_q;
    assign upd_idx   = idx_q;
    assign upd_val   = val_q;
    assign upd_blank = blank_q;
    assign upd_err   = err_q;

endmodule
